// File: rtl/one_time_pad.sv
// One-time-pad XOR cipher that owns the key register; encrypts and decrypts with the same key.
// Latency 1 cycle, one request per cycle; no backpressure, and rejected requests pulse erro.
module one_time_pad #(
    parameter int                    TEXT_SIZE        = 64,
    parameter logic [TEXT_SIZE-1:0]  KEY_INIT         = TEXT_SIZE'(64'hA5A5_5A5A_3C3C_C3C3),
    parameter bit                    ENFORCE_ONE_TIME = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TEXT_SIZE-1:0]  chave,
    input  logic                  chave_carrega,
    input  logic [TEXT_SIZE-1:0]  mensagem,
    input  logic                  mensagem_valida,
    output logic [TEXT_SIZE-1:0]  mensagemCifrada,
    output logic                  cifrada_valida,
    output logic                  chave_nova,
    output logic                  erro
);

    logic [TEXT_SIZE-1:0] keyReg;
    logic                 keyUsable;
    logic                 accept;
    logic                 reject;

    assign keyUsable = !ENFORCE_ONE_TIME || chave_nova;
    assign accept    = mensagem_valida && keyUsable;
    assign reject    = mensagem_valida && !keyUsable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyReg          <= KEY_INIT;
            mensagemCifrada <= '0;
            cifrada_valida  <= 1'b0;
            erro            <= 1'b0;
            chave_nova      <= 1'b1;
        end else begin
            cifrada_valida <= accept;
            erro           <= reject;
            if (accept) begin
                mensagemCifrada <= mensagem ^ keyReg;
            end
            // A load on the same edge as a request wins: the request used the old key.
            if (chave_carrega) begin
                keyReg     <= chave;
                chave_nova <= 1'b1;
            end else if (accept) begin
                chave_nova <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_one_time_pad.sv
// Randomized self-checking bench for one_time_pad: free instance, enforcing instance, and a decrypt stage.
module tb_one_time_pad;

    localparam logic [63:0] KINIT = 64'hA5A5_5A5A_3C3C_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] chave = '0;
    logic        chave_carrega = 1'b0;
    logic [63:0] mensagem = '0;
    logic        mensagem_valida = 1'b0;

    logic [63:0] outA, outE, outR;
    logic        vldA, vldE, vldR;
    logic        newA, newE, newR;
    logic        errA, errE, errR;

    int total = 0;
    int bad   = 0;

    // Behavioural model, index 0 = free instance, 1 = one-time enforcing instance
    logic [63:0] mKey [2];
    logic        mNew [2];
    logic [63:0] mOut [2];
    logic        mVld [2];
    logic        mErr [2];

    always #5 clk = ~clk;

    one_time_pad #(.TEXT_SIZE(64), .KEY_INIT(KINIT), .ENFORCE_ONE_TIME(1'b0)) dutA (
        .clk(clk), .rst(rst), .chave(chave), .chave_carrega(chave_carrega),
        .mensagem(mensagem), .mensagem_valida(mensagem_valida),
        .mensagemCifrada(outA), .cifrada_valida(vldA), .chave_nova(newA), .erro(errA));

    one_time_pad #(.TEXT_SIZE(64), .KEY_INIT(KINIT), .ENFORCE_ONE_TIME(1'b1)) dutE (
        .clk(clk), .rst(rst), .chave(chave), .chave_carrega(chave_carrega),
        .mensagem(mensagem), .mensagem_valida(mensagem_valida),
        .mensagemCifrada(outE), .cifrada_valida(vldE), .chave_nova(newE), .erro(errE));

    one_time_pad #(.TEXT_SIZE(64), .KEY_INIT(KINIT), .ENFORCE_ONE_TIME(1'b0)) dutR (
        .clk(clk), .rst(rst), .chave(chave), .chave_carrega(chave_carrega),
        .mensagem(outA), .mensagem_valida(vldA),
        .mensagemCifrada(outR), .cifrada_valida(vldR), .chave_nova(newR), .erro(errR));

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            mKey[e] = KINIT; mNew[e] = 1'b1; mOut[e] = '0; mVld[e] = 1'b0; mErr[e] = 1'b0;
        end
    endtask

    // Apply one edge of stimulus; called with the time just after a posedge.
    task automatic tick(input logic ld, input logic [63:0] key, input logic v, input logic [63:0] msg);
        logic ok;
        chave = key; chave_carrega = ld; mensagem = msg; mensagem_valida = v;
        @(posedge clk);
        #1;
        for (int e = 0; e < 2; e++) begin
            ok = v && (e == 0 || mNew[e]);
            mVld[e] = ok;
            mErr[e] = v && !ok;
            if (ok) mOut[e] = msg ^ mKey[e];
            if (ld) begin
                mKey[e] = key; mNew[e] = 1'b1;
            end else if (ok) begin
                mNew[e] = 1'b0;
            end
        end
        chave_carrega = 1'b0; mensagem_valida = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b0, '0, 1'b1, 64'h1234_5678_9ABC_DEF0);
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (outA !== 64'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", outA); end
        total++; if (vldA !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", vldA); end
        total++; if (errE !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", errE); end
        total++; if (newA !== 1'b1 || newE !== 1'b1) begin bad++; $display("FAIL reset_new got=%b%b exp=11", newA, newE); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_message();
        tick(1'b0, '0, 1'b1, 64'h0);
        total++; if (outA !== KINIT) begin bad++; $display("FAIL zero_out got=%h exp=%h", outA, KINIT); end
        total++; if (vldA !== 1'b1) begin bad++; $display("FAIL zero_vld got=%b exp=1", vldA); end
        total++; if (newA !== 1'b0) begin bad++; $display("FAIL zero_new got=%b exp=0", newA); end
        tick(1'b0, '0, 1'b0, '0);
        total++; if (vldA !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b exp=0", vldA); end
        total++; if (outA !== KINIT) begin bad++; $display("FAIL zero_hold got=%h exp=%h", outA, KINIT); end
    endtask

    task automatic test_round_trip();
        logic [63:0] msg, key;
        tick(1'b0, '0, 1'b1, 64'h5546_4D47_3230_3234);
        tick(1'b0, '0, 1'b0, '0);
        total++; if (outR !== 64'h5546_4D47_3230_3234 || vldR !== 1'b1) begin
            bad++; $display("FAIL roundtrip_ufmg got=%h/%b exp=5546_4d47_3230_3234/1", outR, vldR);
        end
        for (int i = 0; i < 20; i++) begin
            key = {$urandom, $urandom};
            msg = {$urandom, $urandom};
            tick(1'b1, key, 1'b0, '0);
            tick(1'b0, '0, 1'b1, msg);
            total++; if (outA !== (msg ^ key)) begin bad++; $display("FAIL roundtrip_cipher got=%h exp=%h", outA, msg ^ key); end
            tick(1'b0, '0, 1'b0, '0);
            total++; if (outR !== msg || vldR !== 1'b1) begin bad++; $display("FAIL roundtrip_plain got=%h/%b exp=%h/1", outR, vldR, msg); end
        end
    endtask

    task automatic test_key_complement();
        tick(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, '0);
        total++; if (newA !== 1'b1) begin bad++; $display("FAIL load_new got=%b exp=1", newA); end
        tick(1'b0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (outA !== 64'hFEDC_BA98_7654_3210) begin bad++; $display("FAIL complement got=%h exp=fedcba9876543210", outA); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0);
        total++; if (outA !== KINIT || vldA !== 1'b1) begin bad++; $display("FAIL simul_oldkey got=%h/%b exp=%h/1", outA, vldA, KINIT); end
        total++; if (newA !== 1'b1) begin bad++; $display("FAIL simul_new got=%b exp=1", newA); end
        tick(1'b0, '0, 1'b1, 64'h0);
        total++; if (outA !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL simul_newkey got=%h exp=0123456789abcdef", outA); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b0, '0, 1'b1, 64'h1111_2222_3333_4444);
        total++; if (vldE !== 1'b1 || errE !== 1'b0) begin bad++; $display("FAIL once_first got=%b/%b exp=1/0", vldE, errE); end
        total++; if (outE !== (64'h1111_2222_3333_4444 ^ KINIT)) begin bad++; $display("FAIL once_out got=%h", outE); end
        tick(1'b0, '0, 1'b1, 64'h5555_6666_7777_8888);
        total++; if (errE !== 1'b1 || vldE !== 1'b0) begin bad++; $display("FAIL once_reject got=%b/%b exp=1/0", errE, vldE); end
        total++; if (outE !== (64'h1111_2222_3333_4444 ^ KINIT)) begin bad++; $display("FAIL once_hold got=%h", outE); end
        total++; if (vldA !== 1'b1 || outA !== (64'h5555_6666_7777_8888 ^ KINIT)) begin bad++; $display("FAIL free_reuse got=%h/%b", outA, vldA); end
        tick(1'b0, '0, 1'b0, '0);
        total++; if (errE !== 1'b0) begin bad++; $display("FAIL once_errpulse got=%b exp=0", errE); end
        tick(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, '0);
        tick(1'b0, '0, 1'b1, 64'h0);
        total++; if (vldE !== 1'b1 || outE !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL once_reload got=%h/%b", outE, vldE); end
    endtask

    task automatic test_reset_discard();
        tick(1'b0, '0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
        chave_carrega = 1'b1; chave = 64'hFFFF_0000_FFFF_0000;
        mensagem = 64'h1234_1234_1234_1234; mensagem_valida = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        mensagem_valida = 1'b0; chave_carrega = 1'b0;
        rst = 1'b0;
        tick(1'b0, '0, 1'b0, '0);
        total++; if (vldA !== 1'b0 || vldE !== 1'b0 || errE !== 1'b0) begin bad++; $display("FAIL discard_pulse got=%b%b%b exp=000", vldA, vldE, errE); end
        total++; if (outA !== 64'h0) begin bad++; $display("FAIL discard_out got=%h exp=0", outA); end
        tick(1'b0, '0, 1'b1, 64'h0);
        total++; if (outA !== KINIT || vldA !== 1'b1) begin bad++; $display("FAIL discard_key got=%h/%b exp=%h/1", outA, vldA, KINIT); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 4) == 0), {$urandom, $urandom}, ($urandom_range(0, 2) != 0), {$urandom, $urandom});
            if (outA !== mOut[0] || vldA !== mVld[0] || newA !== mNew[0] || errA !== mErr[0]) begin
                errs++;
                $display("FAIL random_free i=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", i, outA, vldA, newA, errA, mOut[0], mVld[0], mNew[0], mErr[0]);
            end
            if (outE !== mOut[1] || vldE !== mVld[1] || newE !== mNew[1] || errE !== mErr[1]) begin
                errs++;
                $display("FAIL random_once i=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", i, outE, vldE, newE, errE, mOut[1], mVld[1], mNew[1], mErr[1]);
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_summary got=%0d exp=0", errs); end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        test_reset();
        test_zero_message();
        test_round_trip();
        test_key_complement();
        test_simultaneous();
        test_back_to_back();
        test_reset_discard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/one_time_pad.md
# one_time_pad

Registered one-time-pad cipher block: XORs a `TEXT_SIZE`-bit message (packed ASCII, MSB = first character) with a stored key. It returns the result one clock later with a valid strobe. Because XOR is an involution, the same block decrypts when fed a ciphertext under the same key. Two instances in series (encrypt, then decrypt) must reproduce the original message. It sits between the message source and the transport/display path and owns the key register.

## Interface
Parameters:
- `TEXT_SIZE`, default 64: message and key width in bits (8 ASCII characters).
- `KEY_INIT`, default 64'hA5A5_5A5A_3C3C_C3C3: key value loaded at reset. Sized to `TEXT_SIZE`.
- `ENFORCE_ONE_TIME`, default 0: when 1, each key may encrypt exactly one message.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous active-high reset.
- `chave` in TEXT_SIZE: new key value.
- `chave_carrega` in 1: load `chave` into the key register on this edge.
- `mensagem` in TEXT_SIZE: plaintext or ciphertext input.
- `mensagem_valida` in 1: `mensagem` is valid on this edge; a request.
- `mensagemCifrada` out TEXT_SIZE: registered XOR result.
- `cifrada_valida` out 1: one-cycle pulse marking a new result.
- `chave_nova` out 1: the key register holds a key not yet used.
- `erro` out 1: one-cycle pulse marking a request that was rejected.

## Operation
- Internal key register `k`.
- Accepted request:
  - A request is accepted when `mensagem_valida`=1 and either `ENFORCE_ONE_TIME`=0 or `chave_nova`=1.
  - On the edge: `mensagemCifrada` <= `mensagem` ^ `k`, `cifrada_valida` <= 1, `chave_nova` <= 0.
- Rejected request:
  - A request is rejected when `mensagem_valida`=1, `ENFORCE_ONE_TIME`=1 and `chave_nova`=0.
  - On the edge: `erro` <= 1. `mensagemCifrada` holds, and `cifrada_valida` <= 0.
- No request: `cifrada_valida` <= 0 and `erro` <= 0. `mensagemCifrada` holds its last value.
- Key load: when `chave_carrega`=1, `k` <= `chave` and `chave_nova` <= 1.
- Key load and request on the same edge:
  - The request is evaluated against the old `k` and old `chave_nova`.
  - After the edge, `k` is the new key and `chave_nova`=1; the load wins over the clear.
- Arithmetic: pure bitwise XOR, full `TEXT_SIZE` width, with no carry, padding or truncation.
- With `ENFORCE_ONE_TIME`=0, `chave_nova` is still maintained but never blocks a request.

## Timing
- Latency is 1 cycle: a request accepted on edge N produces its result and `cifrada_valida`=1 after edge N, held for exactly one cycle.
- Throughput is one request per cycle. There is no backpressure and no stall.
- The key takes effect on the first request after the loading edge.
- Reset values, applied immediately on `rst`=1 regardless of `clk`:
  - `k`=`KEY_INIT`, `mensagemCifrada`=0, `cifrada_valida`=0, `erro`=0, `chave_nova`=1.
- Reset mid-operation: a request pending on the same edge as reset is discarded and produces no output pulse after reset release.
- While `rst`=1, all inputs are ignored.
- The first edge after `rst` falls is processed normally.

## Test plan
- Reset check: assert `rst`, with no clock edge needed → `mensagemCifrada`=0, `cifrada_valida`=0, `erro`=0, `chave_nova`=1.
- Zero message: `mensagem`=0 with `mensagem_valida`=1 for one edge → next cycle `mensagemCifrada`=64'hA5A5_5A5A_3C3C_C3C3, `cifrada_valida`=1 for one cycle, then 0; `chave_nova`=0.
- Round trip: two instances in series, with `cifrada_valida` of the first driving `mensagem_valida` of the second; apply "UFMG2024" (64'h55464D47_32303234) → the second output equals 64'h55464D47_32303234 two cycles after the request.
- Key load, then complement: load `chave`=64'h0123_4567_89AB_CDEF, then send `mensagem`=64'hFFFF_FFFF_FFFF_FFFF → output 64'hFEDC_BA98_7654_3210.
- Simultaneous load and request: load 64'h0123_4567_89AB_CDEF on the same edge as `mensagem`=0 → output equals `KEY_INIT` (old key); `chave_nova`=1 afterwards.
- One-time enforcement: `ENFORCE_ONE_TIME`=1, two back-to-back requests → first gives `cifrada_valida`=1; second gives `erro`=1 and `mensagemCifrada` unchanged. After a key load, the next request is accepted.
